// File: rtl/riscv_data_mem_if.sv
// Core-side data memory bus: one request per cycle, read data returned combinationally.
// Signal names keep the memory-side direction suffixes of the original flat ports.
interface riscv_data_mem_if;
   logic        data_mem_req_i;
   logic [31:0] data_mem_addr_i;
   logic [1:0]  data_mem_byte_en_i;
   logic        data_mem_wr_i;
   logic [31:0] data_mem_wr_data_i;
   logic [31:0] data_mem_rd_data_o;

   modport master (
      output data_mem_req_i, data_mem_addr_i, data_mem_byte_en_i,
             data_mem_wr_i, data_mem_wr_data_i,
      input  data_mem_rd_data_o
   );

   modport slave (
      input  data_mem_req_i, data_mem_addr_i, data_mem_byte_en_i,
             data_mem_wr_i, data_mem_wr_data_i,
      output data_mem_rd_data_o
   );
endinterface

// File: rtl/riscv_data_mem.sv
// Data-side memory target: byte-lane data RAM plus a 16-byte MMIO window holding
// the console TX FIFO, a free-running cycle counter and sticky error flags.
module riscv_data_mem #(
   parameter logic [31:0] DMEM_BASE     = 32'h0001_0000,
   parameter int unsigned DMEM_WORDS    = 1024,
   parameter logic [31:0] MMIO_BASE     = 32'h8000_0000,
   parameter int unsigned TX_FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   riscv_data_mem_if.slave dmem,
   output logic            tx_valid_o,
   output logic [7:0]      tx_data_o,
   input  logic            tx_ready_i,
   output logic            misaligned_err_o
);

   localparam int unsigned AW = $clog2(DMEM_WORDS);
   localparam int unsigned PW = $clog2(TX_FIFO_DEPTH);
   localparam logic [32:0] DMEM_LIMIT = {1'b0, DMEM_BASE} + (33'(DMEM_WORDS) << 2);

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_RSVD = 2'b10,
      SZ_WORD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      REG_TX     = 2'd0,
      REG_STATUS = 2'd1,
      REG_CYCLE  = 2'd2,
      REG_ERR    = 2'd3
   } mmio_reg_e;

   logic [31:0] addr;
   size_e       size;
   mmio_reg_e   reg_sel;
   logic        ram_hit;
   logic        mmio_hit;
   logic [31:0] ram_offs;
   logic [AW-1:0] ram_idx;
   logic        bad_align;
   logic        misaligned;
   logic        wr_en;
   logic [3:0]  wmask;
   logic [31:0] wdata;
   logic [31:0] mmio_wdata;
   logic [31:0] rd_data;
   logic        unused_offs;

   assign addr     = dmem.data_mem_addr_i;
   assign size     = size_e'(dmem.data_mem_byte_en_i);
   assign reg_sel  = mmio_reg_e'(addr[3:2]);
   assign ram_hit  = ({1'b0, addr} >= {1'b0, DMEM_BASE}) && ({1'b0, addr} < DMEM_LIMIT);
   assign mmio_hit = addr[31:4] == MMIO_BASE[31:4];
   assign ram_offs = addr - DMEM_BASE;
   assign ram_idx  = ram_offs[AW+1:2];
   assign unused_offs = ^{ram_offs[31:AW+2], ram_offs[1:0]};

   // Alignment check covers every write target; a bad write is dropped everywhere.
   always_comb begin
      bad_align = 1'b0;
      case (size)
         SZ_BYTE: bad_align = 1'b0;
         SZ_HALF: bad_align = addr[0];
         SZ_WORD: bad_align = addr[1:0] != 2'b00;
         default: bad_align = 1'b1;
      endcase
   end

   assign misaligned = dmem.data_mem_req_i & dmem.data_mem_wr_i & bad_align;
   assign wr_en      = dmem.data_mem_req_i & dmem.data_mem_wr_i & ~bad_align;

   always_comb begin
      wmask      = '0;
      wdata      = '0;
      mmio_wdata = dmem.data_mem_wr_data_i;
      case (size)
         SZ_BYTE: begin
            wmask      = 4'b0001 << addr[1:0];
            wdata      = {4{dmem.data_mem_wr_data_i[7:0]}};
            mmio_wdata = {24'h0, dmem.data_mem_wr_data_i[7:0]};
         end
         SZ_HALF: begin
            wmask      = addr[1] ? 4'b1100 : 4'b0011;
            wdata      = {2{dmem.data_mem_wr_data_i[15:0]}};
            mmio_wdata = {16'h0, dmem.data_mem_wr_data_i[15:0]};
         end
         SZ_WORD: begin
            wmask = '1;
            wdata = dmem.data_mem_wr_data_i;
         end
         default: ;
      endcase
   end

   logic [31:0] mem_q [DMEM_WORDS];

   always_ff @(posedge clk) begin
      if (wr_en && ram_hit) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (wmask[i]) mem_q[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   logic [7:0]    fifo_q [TX_FIFO_DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [PW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          mis_q, mis_d;
   logic [31:0]   cyc_q, cyc_d;
   logic          fifo_empty;
   logic          fifo_full;
   logic          push_req;
   logic          push;
   logic          pop;
   logic          err_clr;
   logic          cyc_ld;

   assign fifo_empty = count_q == '0;
   assign fifo_full  = count_q == (PW+1)'(TX_FIFO_DEPTH);
   assign pop        = ~fifo_empty & tx_ready_i;
   assign push_req   = wr_en & mmio_hit & (reg_sel == REG_TX);
   // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
   assign push       = push_req & (~fifo_full | pop);
   assign err_clr    = wr_en & mmio_hit & (reg_sel == REG_ERR);
   assign cyc_ld     = wr_en & mmio_hit & (reg_sel == REG_CYCLE);

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      mis_d   = mis_q;
      cyc_d   = cyc_q + 32'd1;

      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase

      if (err_clr) begin
         ovf_d = 1'b0;
         mis_d = 1'b0;
      end else begin
         if (push_req && fifo_full && !pop) ovf_d = 1'b1;
         if (misaligned)                    mis_d = 1'b1;
      end

      if (cyc_ld) cyc_d = mmio_wdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         mis_q   <= 1'b0;
         cyc_q   <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         mis_q   <= mis_d;
         cyc_q   <= cyc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wptr_q] <= dmem.data_mem_wr_data_i[7:0];
   end

   assign tx_valid_o       = ~fifo_empty;
   assign tx_data_o        = fifo_empty ? '0 : fifo_q[rptr_q];
   assign misaligned_err_o = mis_q;

   always_comb begin
      rd_data = '0;
      if (dmem.data_mem_req_i && !dmem.data_mem_wr_i) begin
         if (ram_hit) begin
            rd_data = mem_q[ram_idx];
         end else if (mmio_hit) begin
            case (reg_sel)
               REG_STATUS: rd_data = {29'h0, ovf_q, fifo_full, fifo_empty};
               REG_CYCLE:  rd_data = cyc_q;
               REG_ERR:    rd_data = {30'h0, ovf_q, mis_q};
               default:    rd_data = '0;
            endcase
         end
      end
   end

   assign dmem.data_mem_rd_data_o = rd_data;

endmodule

// File: tb/tb_riscv_data_mem.sv
// Directed bench for riscv_data_mem: stimulus queues expected responses, a negedge
// monitor pops and compares them whenever the DUT presents read data, a TX pop or a probe.
module tb_riscv_data_mem;

   localparam logic [31:0] MMIO_TX  = 32'h8000_0000;
   localparam logic [31:0] MMIO_ST  = 32'h8000_0004;
   localparam logic [31:0] MMIO_CYC = 32'h8000_0008;
   localparam logic [31:0] MMIO_ERR = 32'h8000_000C;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       tx_ready;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       mis_err;
   logic       probe;

   riscv_data_mem_if bus();

   riscv_data_mem #(
      .DMEM_BASE     (32'h0001_0000),
      .DMEM_WORDS    (1024),
      .MMIO_BASE     (32'h8000_0000),
      .TX_FIFO_DEPTH (4)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .dmem             (bus),
      .tx_valid_o       (tx_valid),
      .tx_data_o        (tx_data),
      .tx_ready_i       (tx_ready),
      .misaligned_err_o (mis_err)
   );

   always #5 clk = ~clk;

   typedef enum int {SIG_RD, SIG_TXV, SIG_TXD, SIG_ERR} sig_e;
   typedef struct {
      string       name;
      sig_e        sel;
      logic [31:0] exp;
   } item_t;

   item_t rd_q[$];
   item_t tx_q[$];
   item_t sig_q[$];
   int    n_vec = 0;
   int    n_err = 0;

   function automatic item_t mk(string name, sig_e sel, logic [31:0] exp);
      item_t it;
      it.name = name;
      it.sel  = sel;
      it.exp  = exp;
      return it;
   endfunction

   function automatic logic [31:0] sample(sig_e sel);
      case (sel)
         SIG_RD:  return bus.data_mem_rd_data_o;
         SIG_TXV: return {31'h0, tx_valid};
         SIG_TXD: return {24'h0, tx_data};
         default: return {31'h0, mis_err};
      endcase
   endfunction

   function automatic void cmp(item_t it);
      logic [31:0] act;
      act = sample(it.sel);
      n_vec++;
      if (act !== it.exp) begin
         n_err++;
         $display("FAIL %s: got %08h, expected %08h", it.name, act, it.exp);
      end
   endfunction

   function automatic void orphan(string what);
      n_vec++;
      n_err++;
      $display("FAIL %s: DUT output with no expected entry queued", what);
   endfunction

   // Monitor: decoupled from stimulus, reacts to whatever the DUT presents.
   always @(negedge clk) begin
      if (bus.data_mem_req_i && !bus.data_mem_wr_i) begin
         if (rd_q.size() == 0) orphan("read");
         else cmp(rd_q.pop_front());
      end
      if (tx_valid && tx_ready) begin
         if (tx_q.size() == 0) orphan("tx_pop");
         else cmp(tx_q.pop_front());
      end
      if (probe) begin
         while (sig_q.size() != 0) cmp(sig_q.pop_front());
      end
   end

   task automatic drive(input logic req, input logic wr, input logic [31:0] a,
                        input logic [1:0] be, input logic [31:0] d);
      bus.data_mem_req_i     = req;
      bus.data_mem_wr_i      = wr;
      bus.data_mem_addr_i    = a;
      bus.data_mem_byte_en_i = be;
      bus.data_mem_wr_data_i = d;
      @(posedge clk);
      #1;
   endtask

   task automatic wr_t(input logic [31:0] a, input logic [1:0] be, input logic [31:0] d);
      drive(1'b1, 1'b1, a, be, d);
   endtask

   task automatic rd_t(input string name, input logic [31:0] a, input logic [31:0] exp);
      rd_q.push_back(mk(name, SIG_RD, exp));
      drive(1'b1, 1'b0, a, 2'b11, 32'h0);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
   endtask

   task automatic probe_cycle();
      probe = 1'b1;
      idle(1);
      probe = 1'b0;
   endtask

   task automatic leftover(input string name, input int n);
      n_vec++;
      if (n != 0) begin
         n_err++;
         $display("FAIL %s: %0d expected entries never matched, required 0", name, n);
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      reset_n  = 1'b0;
      tx_ready = 1'b0;
      probe    = 1'b0;
      bus.data_mem_req_i     = 1'b0;
      bus.data_mem_wr_i      = 1'b0;
      bus.data_mem_addr_i    = '0;
      bus.data_mem_byte_en_i = '0;
      bus.data_mem_wr_data_i = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      sig_q.push_back(mk("rst_rd_data", SIG_RD, 32'h0));
      sig_q.push_back(mk("rst_tx_valid", SIG_TXV, 32'h0));
      sig_q.push_back(mk("rst_tx_data", SIG_TXD, 32'h0));
      sig_q.push_back(mk("rst_mis_err", SIG_ERR, 32'h0));
      probe_cycle();
      reset_n = 1'b1;
      rd_t("rst_cycle", MMIO_CYC, 32'h0);
      rd_t("rst_status", MMIO_ST, 32'h1);
      rd_t("rst_err", MMIO_ERR, 32'h0);

      // Byte-lane merge and same-cycle read
      wr_t(32'h0001_0008, 2'b11, 32'hCAFE_F00D);
      wr_t(32'h0001_0004, 2'b11, 32'h0);
      wr_t(32'h0001_0000, 2'b11, 32'hDEAD_BEEF);
      wr_t(32'h0001_0002, 2'b00, 32'h0000_0055);
      rd_t("byte_lane", 32'h0001_0000, 32'hDE55_BEEF);
      rd_t("misaligned_read", 32'h0001_0003, 32'hDE55_BEEF);
      sig_q.push_back(mk("no_flag_on_read", SIG_ERR, 32'h0));
      probe_cycle();

      // Half write, misaligned word write suppressed, sticky flag and clear
      wr_t(32'h0001_0006, 2'b01, 32'h0000_1234);
      wr_t(32'h0001_0009, 2'b11, 32'h1111_1111);
      sig_q.push_back(mk("mis_flag_set", SIG_ERR, 32'h1));
      probe_cycle();
      rd_t("half_write", 32'h0001_0004, 32'h1234_0000);
      rd_t("mis_suppressed", 32'h0001_0008, 32'hCAFE_F00D);
      rd_t("err_reg_mis", MMIO_ERR, 32'h1);
      wr_t(MMIO_ERR, 2'b11, 32'h0);
      sig_q.push_back(mk("mis_flag_cleared", SIG_ERR, 32'h0));
      probe_cycle();
      rd_t("err_reg_cleared", MMIO_ERR, 32'h0);

      // Reserved size and odd half write: both dropped, both flag
      wr_t(32'h0001_0000, 2'b10, 32'h0);
      sig_q.push_back(mk("rsvd_flag", SIG_ERR, 32'h1));
      probe_cycle();
      rd_t("rsvd_suppressed", 32'h0001_0000, 32'hDE55_BEEF);
      wr_t(MMIO_ERR, 2'b11, 32'h0);
      wr_t(32'h0001_0005, 2'b01, 32'h0000_FFFF);
      rd_t("odd_half_suppressed", 32'h0001_0004, 32'h1234_0000);
      rd_t("odd_half_flag", MMIO_ERR, 32'h1);
      wr_t(MMIO_ERR, 2'b11, 32'h0);

      // FIFO fill past full with sink stalled, then drain
      for (int i = 0; i < 5; i++) wr_t(MMIO_TX, 2'b00, 32'h41 + i);
      rd_t("status_full_ovf", MMIO_ST, 32'h6);
      sig_q.push_back(mk("head_valid", SIG_TXV, 32'h1));
      sig_q.push_back(mk("head_is_A", SIG_TXD, 32'h41));
      probe_cycle();
      rd_t("err_ovf", MMIO_ERR, 32'h2);
      for (int i = 0; i < 4; i++) tx_q.push_back(mk("drain_order", SIG_TXD, 32'h41 + i));
      tx_ready = 1'b1;
      idle(4);
      tx_ready = 1'b0;
      rd_t("status_drained", MMIO_ST, 32'h5);
      rd_t("tx_reads_zero", MMIO_TX, 32'h0);
      wr_t(MMIO_ERR, 2'b11, 32'h0);
      rd_t("status_clean", MMIO_ST, 32'h1);

      // Push into a full FIFO while it pops
      for (int i = 0; i < 4; i++) wr_t(MMIO_TX, 2'b00, 32'h41 + i);
      tx_q.push_back(mk("full_pop_A", SIG_TXD, 32'h41));
      tx_ready = 1'b1;
      wr_t(MMIO_TX, 2'b00, 32'h46);
      tx_ready = 1'b0;
      rd_t("full_push_pop", MMIO_ST, 32'h2);
      tx_q.push_back(mk("after_F_B", SIG_TXD, 32'h42));
      tx_q.push_back(mk("after_F_C", SIG_TXD, 32'h43));
      tx_q.push_back(mk("after_F_D", SIG_TXD, 32'h44));
      tx_q.push_back(mk("after_F_F", SIG_TXD, 32'h46));
      tx_ready = 1'b1;
      idle(4);
      tx_ready = 1'b0;
      rd_t("status_empty_no_ovf", MMIO_ST, 32'h1);

      // Cycle counter load and wrap
      wr_t(MMIO_CYC, 2'b11, 32'hFFFF_FFFE);
      rd_t("cyc_load", MMIO_CYC, 32'hFFFF_FFFE);
      rd_t("cyc_max", MMIO_CYC, 32'hFFFF_FFFF);
      rd_t("cyc_wrap", MMIO_CYC, 32'h0000_0000);

      // Decode edges
      rd_t("unmapped", 32'h0000_0100, 32'h0);
      wr_t(32'h0001_0FFC, 2'b11, 32'h0BAD_F00D);
      rd_t("ram_last_word", 32'h0001_0FFC, 32'h0BAD_F00D);
      wr_t(32'h0001_1000, 2'b11, 32'h1234_5678);
      rd_t("past_ram_end", 32'h0001_1000, 32'h0);

      // Reset mid-drain with two entries still queued
      for (int i = 0; i < 3; i++) wr_t(MMIO_TX, 2'b00, 32'h58 + i);
      tx_q.push_back(mk("pre_reset_pop", SIG_TXD, 32'h58));
      tx_ready = 1'b1;
      idle(1);
      #2;
      reset_n = 1'b0;
      sig_q.push_back(mk("rst_mid_valid", SIG_TXV, 32'h0));
      sig_q.push_back(mk("rst_mid_data", SIG_TXD, 32'h0));
      probe = 1'b1;
      rd_t("rst_mid_cycle", MMIO_CYC, 32'h0);
      probe = 1'b0;
      rd_t("ram_retained", 32'h0001_0000, 32'hDE55_BEEF);
      tx_ready = 1'b0;
      reset_n = 1'b1;
      rd_t("status_after_rst", MMIO_ST, 32'h1);
      idle(2);

      leftover("rd_queue", rd_q.size());
      leftover("tx_queue", tx_q.size());
      leftover("probe_queue", sig_q.size());

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/riscv_data_mem.md
Name: riscv_data_mem

Overview:
- Data-side memory target. Sits directly downstream of the core's data memory interface: consumes req/addr/byte_en/wr/wr_data and returns rd_data in the same cycle, as the single-cycle datapath requires.
- Contains a word-organised data RAM with byte-lane writes.
- Contains a small memory-mapped peripheral window: console TX FIFO with valid/ready drain port, free-running cycle counter, and sticky error flags.

Parameters:
- DMEM_BASE, 32'h0001_0000, byte base address of the data RAM.
- DMEM_WORDS, 1024, RAM depth in 32-bit words. Power of 2.
- MMIO_BASE, 32'h8000_0000, byte base address of the 16-byte peripheral window.
- TX_FIFO_DEPTH, 4, console FIFO entries. Power of 2, ≥2.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- data_mem_req_i  in  1  access valid this cycle
- data_mem_addr_i  in  32  byte address
- data_mem_byte_en_i  in  2  size: 2'b00 byte, 2'b01 half, 2'b11 word (2'b10 reserved)
- data_mem_wr_i  in  1  1 = write, 0 = read
- data_mem_wr_data_i  in  32  write data, right-aligned (byte in [7:0], half in [15:0])
- data_mem_rd_data_o  out  32  read data, full aligned word, combinational
- tx_valid_o  out  1  console FIFO head valid
- tx_data_o  out  8  console FIFO head byte
- tx_ready_i  in  1  console sink accepts head
- misaligned_err_o  out  1  sticky misaligned/reserved-size write flag

Behaviour:
- One clock domain. Async active-low reset on all control state; RAM array is not reset (sim init 0).
- Reset values:
  - data_mem_rd_data_o follows the read path: 0 while req=0.
  - tx_valid_o=0, tx_data_o=0, misaligned_err_o=0.
  - FIFO empty; overflow flag 0; cycle counter 0.
- Decode:
  - RAM hit: DMEM_BASE ≤ addr < DMEM_BASE + 4*DMEM_WORDS.
  - MMIO hit: addr[31:4] == MMIO_BASE[31:4].
  - Anything else unmapped: writes ignored, reads return 0.
- Reads (req=1, wr=0): combinational, zero latency. Return the full word at addr[31:2]; byte_en and addr[1:0] are ignored. The core performs lane extraction and sign/zero extension.
- RAM writes (req=1, wr=1): commit on the clk rising edge. Lanes:
  - Byte: wr_data[7:0] → lane addr[1:0].
  - Half: wr_data[15:0] → lanes {addr[1],0}/{addr[1],1}.
  - Word: all lanes.
- Misaligned write: half with addr[0]=1, word with addr[1:0]≠0, or byte_en=2'b10. Effect:
  - write suppressed entirely (RAM and MMIO);
  - misaligned_err_o set next cycle; it stays set until cleared.
- Misaligned read: returns the aligned word; no flag.
- MMIO map (offset from MMIO_BASE; word accesses; sub-word writes to MMIO use wr_data low bits):
  - 0x0 TX: write pushes wr_data[7:0] if FIFO not full; if full, byte dropped and overflow set. Reads 0.
  - 0x4 STATUS (read-only): {29'b0, overflow, full, empty}.
  - 0x8 CYCLE: read returns current count. Write loads wr_data; the loaded value is visible the next cycle, then increments. Write has priority over increment.
  - 0xC ERR: read {30'b0, overflow, misaligned}. Any write clears both flags. Clear has priority over a same-cycle set.
- Cycle counter: +1 every cycle out of reset; wraps 32'hFFFF_FFFF → 0.
- TX FIFO: circular, read/write pointers plus count.
  - tx_valid_o = !empty; tx_data_o = head (0 when empty).
  - Pop on tx_valid_o & tx_ready_i.
  - Push and pop in the same cycle:
    - when full: both happen, count unchanged, no overflow;
    - when empty: push only; pop is impossible because valid=0.
  - Pointers wrap modulo TX_FIFO_DEPTH.
  - Head byte is stable while valid=1 and ready=0.
- Reset asserted mid-operation: FIFO flushed, flags and counter cleared immediately (async). RAM contents retained.
- req=0: no state change except the cycle counter and FIFO pop.

Test Plan:
- Word write 0xDEADBEEF @0x0001_0000, then byte write 0x55 @0x0001_0002 → read @0x0001_0000 returns 0xDE55BEEF, same cycle as req.
- Half write 0x1234 @0x0001_0006, then word write @0x0001_0009 → @0x0001_0004 reads 0x12340000; @0x0001_0008 unchanged; misaligned_err_o=1 next cycle; ERR write clears it to 0.
- With tx_ready_i=0, push 'A','B','C','D','E' to 0x8000_0000 → STATUS=3'b110, tx_data_o='A', 'E' lost; then ready=1 for 4 cycles → 'A','B','C','D' drained in order, STATUS=3'b101.
- FIFO full, ready=1, push 'F' in the same cycle → 'A' popped, 'F' accepted, no overflow; count stays 4.
- Write 0xFFFF_FFFE to CYCLE → reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 on successive cycles.
- Read @0x0000_0100 (unmapped) → 0; deassert reset_n mid-drain with 2 entries queued → tx_valid_o=0, counter=0 immediately; RAM word @0x0001_0000 still 0xDE55BEEF.
